// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and counter width.
package rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned GRANTCNT_W = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit searching from pointer upward,
// wrapping modulo N. Result is one-hot pick plus its binary index.
module rr_pick #(
  parameter  int N   = 16,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   request,
  input  logic [IDW-1:0] pointer,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           any
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_pick;
  logic         found;

  // Rotate so pointer lands at bit 0, fixed-priority scan, then rotate back.
  always_comb begin
    rot_req  = N'({request, request} >> pointer);
    rot_pick = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot_req[i] && !found) begin
        rot_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
    pick    = N'(({rot_pick, rot_pick} << pointer) >> N);
    pick_id = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i]) pick_id = IDW'(i);
    end
  end

  assign any = |request;

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant hold, optional tenure cap (MAXHOLD) and
// optional grant counter enabled by defining RR_ARBITER_GRANTCNT_EN.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int MAXHOLD = 0,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [N-1:0]   request,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
`ifdef RR_ARBITER_GRANTCNT_EN
  ,
  output logic [GRANTCNT_W-1:0] grant_count
`endif
);

  localparam int              HCW       = $clog2(MAXHOLD + 2);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(N - 1);

  arb_state_t     state;
  logic [IDW-1:0] pointer;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] pick_ptr;
  logic [HCW-1:0] hold_cnt;
  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;
  logic           any;
  logic           forced;
  logic           release_now;
  logic           load_new;

  // On release the search already uses the advanced pointer, so re-arbitration has no bubble.
  always_comb begin
    forced      = (MAXHOLD != 0) && (hold_cnt == HOLD_LAST) && (|(request & ~grant));
    release_now = (state == ARB_BUSY) && (done || !request[grant_id] || forced);
    next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    pick_ptr    = release_now ? next_ptr : pointer;
    load_new    = any && ((state == ARB_IDLE) || release_now);
  end

  rr_pick #(.N(N)) u_pick (
    .request (request),
    .pointer (pick_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ARB_IDLE;
      pointer     <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      if (release_now) pointer <= next_ptr;
      if (load_new) begin
        state       <= ARB_BUSY;
        grant       <= pick;
        grant_id    <= pick_id;
        grant_valid <= 1'b1;
        hold_cnt    <= '0;
      end else if (release_now) begin
        state       <= ARB_IDLE;
        grant       <= '0;
        grant_id    <= '0;
        grant_valid <= 1'b0;
        hold_cnt    <= '0;
      end else if ((state == ARB_BUSY) && (hold_cnt != '1)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

`ifdef RR_ARBITER_GRANTCNT_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) grant_count <= '0;
    else if (load_new) grant_count <= grant_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: N=4 unlimited-hold instance plus an N=4, MAXHOLD=3 instance.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] request, req_mh;
  logic       done, done_mh;
  logic [3:0] grant, grant_mh;
  logic       grant_valid, grant_valid_mh;
  logic [1:0] grant_id, grant_id_mh;
`ifdef RR_ARBITER_GRANTCNT_EN
  logic [31:0] grant_count, grant_count_mh;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .MAXHOLD(0)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .request     (request),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
`ifdef RR_ARBITER_GRANTCNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  rr_arbiter #(.N(4), .MAXHOLD(3)) dut_mh (
    .clk         (clk),
    .nreset      (nreset),
    .request     (req_mh),
    .done        (done_mh),
    .grant       (grant_mh),
    .grant_valid (grant_valid_mh),
    .grant_id    (grant_id_mh)
`ifdef RR_ARBITER_GRANTCNT_EN
    ,
    .grant_count (grant_count_mh)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic       dn;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string name, input logic [3:0] g, input logic [1:0] id);
    chk({name, ".grant"}, 32'(grant), 32'(g));
    chk({name, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({name, ".id"}, 32'(grant_id), 32'(id));
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    request = r;
    done    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // after reset: pointer 0, first grant 0 loaded
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
    vecs[5]  = '{4'b0101, 1'b0, 4'b0001, 2'd0};
    vecs[6]  = '{4'b0101, 1'b0, 4'b0001, 2'd0};
    vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[8]  = '{4'b0011, 1'b1, 4'b0001, 2'd0};
    vecs[9]  = '{4'b0011, 1'b0, 4'b0001, 2'd0};
    vecs[10] = '{4'b1000, 1'b0, 4'b1000, 2'd3};
    vecs[11] = '{4'b1000, 1'b1, 4'b1000, 2'd3};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd0};
    vecs[14] = '{4'b0110, 1'b0, 4'b0010, 2'd1};
    vecs[15] = '{4'b1111, 1'b0, 4'b0010, 2'd1};
    vecs[16] = '{4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd0};

    nreset  = 1'b0;
    request = 4'b1111;
    done    = 1'b0;
    req_mh  = 4'b0000;
    done_mh = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_main("reset", 4'b0000, 2'd0);
    chk("reset.mh_grant", 32'(grant_mh), 32'd0);

    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk_main("first_grant", 4'b0001, 2'd0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].req, vecs[i].dn);
      chk_main($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_id);
    end

    // idle with pointer 3: search 3,0 picks 0, then hold for 10 cycles
    for (int c = 0; c < 10; c++) begin
      step(4'b0101, 1'b0);
      chk_main($sformatf("hold%0d", c), 4'b0001, 2'd0);
    end
    step(4'b0100, 1'b0);
    chk_main("hold_drop", 4'b0100, 2'd2);

    // asynchronous reset mid-grant, pointer is 1 before reset
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    chk_main("async_rst", 4'b0000, 2'd0);
    @(negedge clk);
    request = 4'b1001;
    nreset  = 1'b1;
    @(posedge clk);
    #1;
    chk_main("post_rst_ptr0", 4'b0001, 2'd0);

    // MAXHOLD=3 instance: forced release after exactly three grant cycles
    @(negedge clk);
    request = 4'b0000;
    req_mh  = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mh_hold%0d", c), 32'(grant_mh), 32'b0001);
    end
    @(posedge clk);
    #1;
    chk("mh_forced.grant", 32'(grant_mh), 32'b0010);
    chk("mh_forced.id", 32'(grant_id_mh), 32'd1);
    @(negedge clk);
    req_mh = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mh_sole%0d", c), 32'(grant_mh), 32'b0001);
    end
    chk("mh_sole.valid", 32'(grant_valid_mh), 32'd1);

`ifdef RR_ARBITER_GRANTCNT_EN
    @(negedge clk);
    req_mh  = 4'b0000;
    request = 4'b0000;
    nreset  = 1'b0;
    #1;
    chk("cnt_reset", grant_count, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b1);
    chk("cnt_after8", grant_count, 32'd8);
    chk_main("cnt_rot_id", 4'b1000, 2'd3);
    #2;
    nreset = 1'b0;
    #1;
    chk("cnt_async_rst", grant_count, 32'd0);
    chk_main("cnt_async_grant", 4'b0000, 2'd0);
    nreset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
